// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready handshakes and bit-serial shifts.
// Define ALU_SEQ_MUL_EN to add opcode 9, an unsigned shift-add multiply.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] ra,
  input  logic [WIDTH-1:0] rb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

  state_t           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] r_d;
  logic             c_d, z_en, multi;
  logic [CNT_W-1:0] cnt_init;

  logic [WIDTH-1:0] step_acc;
  logic             step_c;

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] a_q, hi, step_hi;
  logic [WIDTH:0]   madd;
`endif

  always_comb begin
    sum      = {1'b0, ra} + {1'b0, rb};
    diff     = {1'b0, ra} - {1'b0, rb};
    r_d      = ra;
    c_d      = 1'b0;
    z_en     = 1'b0;
    multi    = 1'b0;
    cnt_init = CNT_W'(rb);
    case (op)
      4'd1: begin
        r_d  = sum[WIDTH-1:0];
        c_d  = sum[WIDTH];
        z_en = 1'b1;
      end
      4'd2: begin
        r_d  = diff[WIDTH-1:0];
        c_d  = diff[WIDTH];
        z_en = 1'b1;
      end
      4'd3: begin
        r_d  = ~(ra & rb);
        z_en = 1'b1;
      end
      4'd4, 4'd5: begin
        z_en = 1'b1;
        if (rb == '0) begin
          r_d = ra;
        end else if (rb >= W_VAL) begin
          // Only a shift by exactly WIDTH still has a bit to push out
          r_d = '0;
          if (rb == W_VAL)
            c_d = (op == 4'd4) ? ra[0] : ra[WIDTH-1];
        end else begin
          multi = 1'b1;
        end
      end
      4'd7, 4'd8: r_d = rb;
`ifdef ALU_SEQ_MUL_EN
      4'd9: begin
        multi    = 1'b1;
        z_en     = 1'b1;
        cnt_init = CNT_W'(WIDTH);
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    step_acc = acc;
    step_c   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    step_hi  = hi;
    madd     = {1'b0, hi} + (acc[0] ? {1'b0, a_q} : '0);
`endif
    case (op_q)
      4'd4: begin
        step_acc = {acc[WIDTH-2:0], 1'b0};
        step_c   = acc[WIDTH-1];
      end
      4'd5: begin
        step_acc = {1'b0, acc[WIDTH-1:1]};
        step_c   = acc[0];
      end
`ifdef ALU_SEQ_MUL_EN
      4'd9: begin
        // {hi, acc} shifts right; multiplier bits drain out of acc
        step_hi  = madd[WIDTH:1];
        step_acc = {madd[0], acc[WIDTH-1:1]};
        step_c   = |madd[WIDTH:1];
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = multi ? BUSY : DONE;
      end
      BUSY: begin
        if (cnt == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_n <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      a_q    <= '0;
      hi     <= '0;
`endif
    end else if (state_q == IDLE && in_valid) begin
      op_q <= op;
      cnt  <= cnt_init;
      acc  <= ra;
`ifdef ALU_SEQ_MUL_EN
      a_q  <= ra;
      hi   <= '0;
      if (op == 4'd9) acc <= rb;
`endif
      if (!multi) begin
        result <= r_d;
        flag_c <= c_d;
        flag_z <= z_en && (r_d == '0);
        flag_n <= r_d[WIDTH-1];
      end
    end else if (state_q == BUSY) begin
      acc <= step_acc;
      cnt <= cnt - CNT_W'(1);
`ifdef ALU_SEQ_MUL_EN
      hi  <= step_hi;
`endif
      if (cnt == CNT_W'(1)) begin
        result <= step_acc;
        flag_c <= step_c;
        flag_z <= (step_acc == '0);
        flag_n <= step_acc[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq (WIDTH=8) with a behavioural model.
// Honours ALU_SEQ_MUL_EN in the model when the design is built with it.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] ra, rb;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         flag_z, flag_c, flag_n;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .ra(ra), .rb(rb),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n)
  );

  function automatic void model(
    input  logic [3:0]   o,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] r,
    output logic         c,
    output logic         z,
    output int           lat
  );
    int p;
    int bi;
    logic zen;
    r = a; c = 1'b0; lat = 1; zen = 1'b0;
    bi = int'(b);
    case (o)
      4'd1: begin
        p = int'(a) + int'(b);
        r = p[W-1:0]; c = (p > 255); zen = 1'b1;
      end
      4'd2: begin
        r = a - b; c = (a < b); zen = 1'b1;
      end
      4'd3: begin
        r = ~(a & b); zen = 1'b1;
      end
      4'd4: begin
        zen = 1'b1;
        if (bi > W) r = '0;
        else if (bi > 0) begin
          r = a << bi; c = a[W-bi];
          if (bi < W) lat = 1 + bi;
        end
      end
      4'd5: begin
        zen = 1'b1;
        if (bi > W) r = '0;
        else if (bi > 0) begin
          r = a >> bi; c = a[bi-1];
          if (bi < W) lat = 1 + bi;
        end
      end
      4'd7, 4'd8: r = b;
`ifdef ALU_SEQ_MUL_EN
      4'd9: begin
        p = int'(a) * int'(b);
        r = p[W-1:0]; c = (p > 255); zen = 1'b1; lat = 1 + W;
      end
`endif
      default: ;
    endcase
    z = zen && (r == '0);
  endfunction

  task automatic do_op(input string tag, input logic [3:0] o,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] er;
    logic ec, ez;
    int elat, cyc;
    model(o, a, b, er, ec, ez, elat);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1)
      $display("FAIL %s ready_before got=%b want=1", tag, in_ready);
    else passed++;
    in_valid = 1'b1; op = o; ra = a; rb = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op = 4'($urandom); ra = W'($urandom); rb = W'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 64) begin
      total++;
      if (in_ready !== 1'b0)
        $display("FAIL %s busy_ready got=%b want=0", tag, in_ready);
      else passed++;
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc !== elat || out_valid !== 1'b1)
      $display("FAIL %s latency got=%0d valid=%b want=%0d", tag, cyc, out_valid, elat);
    else passed++;
    total++;
    if ({result, flag_c, flag_z, flag_n} !== {er, ec, ez, er[W-1]})
      $display("FAIL %s op=%0d a=%h b=%h result/czn got=%h/%b%b%b want=%h/%b%b%b",
               tag, o, a, b, result, flag_c, flag_z, flag_n, er, ec, ez, er[W-1]);
    else passed++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL %s release got valid=%b ready=%b want 0/1", tag, out_valid, in_ready);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; ra = '0; rb = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({out_valid, in_ready, result, flag_z, flag_c, flag_n} !== {2'b01, 8'h00, 3'b000})
      $display("FAIL reset got valid=%b ready=%b result=%h zcn=%b%b%b want 0 1 00 000",
               out_valid, in_ready, result, flag_z, flag_c, flag_n);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    do_op("add_ff_01", 4'd1, 8'hFF, 8'h01);
    do_op("sub_05_07", 4'd2, 8'h05, 8'h07);
    do_op("mov_zero",  4'd8, 8'h55, 8'h00);
    do_op("shl_81_3",  4'd4, 8'h81, 8'd3);
    do_op("shr_81_8",  4'd5, 8'h81, 8'd8);
    do_op("shl_81_8",  4'd4, 8'h81, 8'd8);
    do_op("shr_81_9",  4'd5, 8'h81, 8'd9);
    do_op("shr_80_0",  4'd5, 8'h80, 8'd0);
    do_op("shr_c3_7",  4'd5, 8'hC3, 8'd7);
    do_op("in_op",     4'd7, 8'h12, 8'h9A);
    do_op("nop_6",     4'd6, 8'h00, 8'h33);
    do_op("op9",       4'd9, 8'h10, 8'h11);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    in_valid = 1'b1; op = 4'd3; ra = 8'hF0; rb = 8'hFF;
    @(negedge clk);
    op = 4'd1; ra = 8'h01; rb = 8'h01;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({out_valid, in_ready, result, flag_c, flag_z, flag_n} !== {2'b10, 8'h0F, 3'b000})
        $display("FAIL hold_%0d got valid=%b ready=%b result=%h czn=%b%b%b want 1 0 0f 000",
                 i, out_valid, in_ready, result, flag_c, flag_z, flag_n);
      else passed++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL hold_release got valid=%b ready=%b want 0/1", out_valid, in_ready);
    else passed++;
    repeat (2) @(negedge clk);
    total++;
    if (out_valid !== 1'b0)
      $display("FAIL hold_ignored got valid=%b want=0", out_valid);
    else passed++;
  endtask

  task automatic test_reset_busy();
    @(negedge clk);
    in_valid = 1'b1; op = 4'd4; ra = 8'hA7; rb = 8'd5;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({out_valid, in_ready, result, flag_z, flag_c, flag_n} !== {2'b01, 8'h00, 3'b000})
      $display("FAIL rst_busy got valid=%b ready=%b result=%h zcn=%b%b%b want 0 1 00 000",
               out_valid, in_ready, result, flag_z, flag_c, flag_n);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    do_op("add_after_rst", 4'd1, 8'd2, 8'd3);
  endtask

  task automatic test_random();
    logic [3:0]   o;
    logic [W-1:0] a, b;
    for (int i = 0; i < 150; i++) begin
      o = 4'($urandom_range(0, 15));
      a = W'($urandom);
      b = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 10)) : W'($urandom);
      do_op("random", o, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_busy();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
